// File: rtl/fifo_collector_pkg.sv
// -----------------------------------------------------------------------------
// fifo_collector_pkg
// Shared declarations for the result-FIFO collector:
//   NUM_BLOCKS         number of polled blocks (indices 1..12)
//   DEFAULT_DATA_BITS  default word width
//   blk_idx_t          block index type (0 means "none")
//   collector_state_t  collector FSM states
//   next_ptr()         round-robin successor of a block index
//   idx_onehot()       block index to one-hot request vector
// -----------------------------------------------------------------------------
package fifo_collector_pkg;

  localparam int NUM_BLOCKS        = 12;
  localparam int DEFAULT_DATA_BITS = 64;

  typedef bit [3:0] blk_idx_t;

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_REQ,
    ST_WAIT,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } collector_state_t;

  // Successor in the 1..12 ring: 12 wraps to 1.
  function automatic blk_idx_t next_ptr(input blk_idx_t i);
    return (i == 4'd12) ? 4'd1 : i + 4'd1;
  endfunction

  function automatic logic [1:NUM_BLOCKS] idx_onehot(input blk_idx_t i);
    logic [1:NUM_BLOCKS] v;
    v = '0;
    for (int k = 1; k <= NUM_BLOCKS; k++) begin
      v[k] = (i == 4'(k));
    end
    return v;
  endfunction

endpackage

// File: rtl/fifo_collector_rr_pick12.sv
// -----------------------------------------------------------------------------
// rr_pick12
// Combinational round-robin selector over twelve blocks. Starting at ptr and
// walking upward with wrap (12 -> 1), returns the first block whose FIFO is
// not empty.
// Ports:
//   fifo_empty  in  [1:12]  per-block empty flags
//   ptr         in  4       search start index, 1..12
//   found       out 1       some block is non-empty
//   idx         out 4       selected block index (0 when nothing found)
// -----------------------------------------------------------------------------
module rr_pick12
  import fifo_collector_pkg::*;
(
  input  logic [1:NUM_BLOCKS] fifo_empty,
  input  blk_idx_t            ptr,
  output logic                found,
  output blk_idx_t            idx
);

  // cand[gi] is the block visited at search offset gi from ptr.
  blk_idx_t              cand [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] avail;

  for (genvar gi = 0; gi < NUM_BLOCKS; gi++) begin : g_cand
    logic [4:0] sum;
    assign sum       = 5'(ptr) + 5'(gi);
    assign cand[gi]  = (sum > 5'd12) ? 4'(sum - 5'd12) : sum[3:0];
    assign avail[gi] = !fifo_empty[cand[gi]];
  end

  // Walk from the far end so the smallest offset wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
      if (avail[i]) begin
        found = 1'b1;
        idx   = cand[i];
      end
    end
  end

endmodule

// File: rtl/fifo_collector.sv
// -----------------------------------------------------------------------------
// fifo_collector
// Host-side reader for the per-block result FIFOs. Polls the empty flags,
// grants one non-empty block with a one-cycle request pulse, deserialises its
// word (MSB first) from the shared registered serial line, and presents the
// word with its source index on a valid/ready interface.
// Ports:
//   fifo_clk    in  1          clock
//   fifo_rst    in  1          synchronous active-high reset
//   fifo_empty  in  [1:12]     per-block FIFO empty
//   fifo_req    out [1:12]     one-hot, one-cycle read request
//   fifo_bit    in  1          OR of all block serial outputs, registered
//   out_data    out DATA_BITS  assembled word
//   out_src     out 4          source block index 1..12
//   out_valid   out 1          word available
//   out_ready   in  1          downstream accepts
//   busy        out 1          collector is not scanning
//   words_read  out 32         completed word count, wraps
// All outputs are registered.
// -----------------------------------------------------------------------------
module fifo_collector
  import fifo_collector_pkg::*;
#(
  parameter int DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int REQ_LATENCY = 2,
  parameter int GAP         = 2
) (
  input  logic                 fifo_clk,
  input  logic                 fifo_rst,
  input  logic [1:NUM_BLOCKS]  fifo_empty,
  output logic [1:NUM_BLOCKS]  fifo_req,
  input  logic                 fifo_bit,
  output logic [DATA_BITS-1:0] out_data,
  output logic [3:0]           out_src,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [31:0]          words_read
);

  localparam int LAT_W  = $clog2(REQ_LATENCY + 2);
  localparam int GAP_W  = $clog2(GAP + 2);
  localparam int BCNT_W = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

  collector_state_t     state_reg;
  blk_idx_t             ptr_reg;
  blk_idx_t             sel_reg;
  logic [LAT_W-1:0]     lat_cnt_reg;
  logic [GAP_W-1:0]     gap_cnt_reg;
  logic [BCNT_W-1:0]    bcnt_reg;
  logic [DATA_BITS-1:0] shreg_reg;
  logic [DATA_BITS-1:0] shreg_next;

  logic     pick_found;
  blk_idx_t pick_idx;

  rr_pick12 u_pick (
    .fifo_empty (fifo_empty),
    .ptr        (ptr_reg),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  // The last bit is folded in on the same edge the word is published.
  assign shreg_next = {shreg_reg[DATA_BITS-2:0], fifo_bit};

  always_ff @(posedge fifo_clk) begin
    if (fifo_rst) begin
      state_reg   <= ST_SCAN;
      ptr_reg     <= 4'd1;
      sel_reg     <= '0;
      lat_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      bcnt_reg    <= '0;
      shreg_reg   <= '0;
      fifo_req    <= '0;
      out_data    <= '0;
      out_src     <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      words_read  <= '0;
    end else begin
      // Request is a single-cycle pulse; only the SCAN hit raises it.
      fifo_req <= '0;

      case (state_reg)
        ST_SCAN: begin
          if (pick_found) begin
            sel_reg   <= pick_idx;
            fifo_req  <= idx_onehot(pick_idx);
            state_reg <= ST_REQ;
            busy      <= 1'b1;
          end
        end

        ST_REQ: begin
          if (REQ_LATENCY <= 1) begin
            bcnt_reg  <= BCNT_W'(DATA_BITS - 1);
            state_reg <= ST_SHIFT;
          end else begin
            lat_cnt_reg <= LAT_W'(REQ_LATENCY - 1);
            state_reg   <= ST_WAIT;
          end
        end

        // Leaving when the counter would reach 0 puts the first SHIFT cycle
        // exactly REQ_LATENCY cycles after the request pulse.
        ST_WAIT: begin
          if (lat_cnt_reg <= LAT_W'(1)) begin
            bcnt_reg  <= BCNT_W'(DATA_BITS - 1);
            state_reg <= ST_SHIFT;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
          end
        end

        ST_SHIFT: begin
          shreg_reg <= shreg_next;
          if (bcnt_reg == '0) begin
            out_data   <= shreg_next;
            out_src    <= sel_reg;
            out_valid  <= 1'b1;
            words_read <= words_read + 32'd1;
            ptr_reg    <= next_ptr(sel_reg);
            state_reg  <= ST_HOLD;
          end else begin
            bcnt_reg <= bcnt_reg - BCNT_W'(1);
          end
        end

        ST_HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (GAP == 0) begin
              state_reg <= ST_SCAN;
              busy      <= 1'b0;
            end else begin
              gap_cnt_reg <= GAP_W'(GAP);
              state_reg   <= ST_GAP;
            end
          end
        end

        // Spends exactly GAP cycles here so the granted block's empty flag
        // has settled before the next scan.
        ST_GAP: begin
          if (gap_cnt_reg <= GAP_W'(1)) begin
            state_reg <= ST_SCAN;
            busy      <= 1'b0;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
          end
        end

        default: begin
          state_reg <= ST_SCAN;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_collector.sv
// -----------------------------------------------------------------------------
// tb_fifo_collector
// Directed bench for fifo_collector with default parameters. A block model
// answers each request pulse by driving that block's word MSB first, starting
// two cycles after the pulse cycle. Inputs change on the falling edge or just
// after the rising edge; outputs are examined on the falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_collector;

  logic        fifo_clk;
  logic        fifo_rst;
  logic [1:12] fifo_empty;
  logic [1:12] fifo_req;
  logic        fifo_bit;
  logic [63:0] out_data;
  logic [3:0]  out_src;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [31:0] words_read;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int pulse_idx_q [$];
  int pulse_cyc_q [$];

  logic [63:0] drv_word;

  fifo_collector #(
    .DATA_BITS   (64),
    .REQ_LATENCY (2),
    .GAP         (2)
  ) dut (
    .fifo_clk   (fifo_clk),
    .fifo_rst   (fifo_rst),
    .fifo_empty (fifo_empty),
    .fifo_req   (fifo_req),
    .fifo_bit   (fifo_bit),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .words_read (words_read)
  );

  initial fifo_clk = 1'b0;
  always #5 fifo_clk = ~fifo_clk;

  always @(posedge fifo_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", tag, got, cyc);
    end
  endtask

  function automatic logic [63:0] blk_word(input int b);
    logic [7:0] bb;
    bb = b[7:0];
    if (b == 5) return 64'hDEADBEEF_01234567;
    return {8'hB0 + bb, 48'h1122_3344_5566, bb};
  endfunction

  function automatic int req_index(input logic [1:12] r);
    int v;
    v = 0;
    for (int i = 1; i <= 12; i++) if (r[i]) v = i;
    return v;
  endfunction

  // Request monitor: records every pulse with its cycle number.
  always @(posedge fifo_clk) begin
    #2;
    if (fifo_req != '0) begin
      check("req_onehot", 64'($countones(fifo_req)), 64'd1);
      pulse_idx_q.push_back(req_index(fifo_req));
      pulse_cyc_q.push_back(cyc);
    end
  end

  // Block model: answers a pulse seen in cycle P with bits in P+2..P+65.
  always begin
    @(posedge fifo_clk);
    #1;
    if (fifo_req != '0 && !fifo_rst) begin
      drv_word = blk_word(req_index(fifo_req));
      @(posedge fifo_clk);
      for (int k = 63; k >= 0; k--) begin
        @(posedge fifo_clk);
        #1;
        if (fifo_rst) break;
        fifo_bit = drv_word[k];
      end
      if (!fifo_rst) begin
        @(posedge fifo_clk);
        #1;
      end
      fifo_bit = 1'b0;
    end
  end

  task automatic wait_pulses(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (pulse_idx_q.size() < n && k < budget) begin
      @(negedge fifo_clk);
      k++;
    end
    check({tag, "_pulses"}, 64'(pulse_idx_q.size() >= n), 64'd1);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int k;
    k = 0;
    while (out_valid !== 1'b1 && k < budget) begin
      @(negedge fifo_clk);
      k++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] data_hold;
    int          np, stable_bad, r, p, n_req, n_busy;
    int          exp_rr [5];

    fifo_rst   = 1'b1;
    fifo_empty = '1;
    fifo_bit   = 1'b0;
    out_ready  = 1'b0;
    repeat (3) @(negedge fifo_clk);

    // Reset state
    check("rst_req",    64'(fifo_req),   64'd0);
    check("rst_valid",  64'(out_valid),  64'd0);
    check("rst_data",   out_data,        64'd0);
    check("rst_src",    64'(out_src),    64'd0);
    check("rst_busy",   64'(busy),       64'd0);
    check("rst_words",  64'(words_read), 64'd0);
    fifo_rst = 1'b0;

    // Single word from block 5, held under backpressure
    pulse_idx_q.delete();
    pulse_cyc_q.delete();
    fifo_empty[5] = 1'b0;
    wait_pulses(1, 50, "single");
    check("single_idx", 64'(pulse_idx_q[0]), 64'd5);
    wait_valid(200, "single");
    check("single_data",  out_data,        64'hDEADBEEF_01234567);
    check("single_src",   64'(out_src),    64'd5);
    check("single_words", 64'(words_read), 64'd1);
    check("single_busy",  64'(busy),       64'd1);

    data_hold  = out_data;
    np         = pulse_idx_q.size();
    stable_bad = 0;
    repeat (200) begin
      @(negedge fifo_clk);
      if (out_valid !== 1'b1 || out_data !== data_hold || out_src !== 4'd5) stable_bad++;
    end
    check("bp_stable", 64'(stable_bad), 64'd0);
    check("bp_no_req", 64'(pulse_idx_q.size()), 64'(np));

    // Accept at the end of cycle r; gap cycles r+1, r+2, scan r+3, pulse r+4.
    out_ready = 1'b1;
    r = cyc;
    @(negedge fifo_clk);
    check("bp_accept", 64'(out_valid), 64'd0);
    wait_pulses(2, 20, "bp_req2");
    check("bp_req2_idx",   64'(pulse_idx_q[1]), 64'd5);
    check("bp_req2_delay", 64'(pulse_cyc_q[1] - r), 64'd4);
    fifo_empty[5] = 1'b1;
    wait_valid(100, "bp_word2");
    check("bp_word2_data",  out_data,        64'hDEADBEEF_01234567);
    check("bp_word2_words", 64'(words_read), 64'd2);
    repeat (10) @(negedge fifo_clk);

    // Round robin over 3, 7, 12 from a fresh ptr=1
    fifo_rst = 1'b1;
    repeat (2) @(negedge fifo_clk);
    fifo_rst = 1'b0;
    pulse_idx_q.delete();
    pulse_cyc_q.delete();
    fifo_empty[3]  = 1'b0;
    fifo_empty[7]  = 1'b0;
    fifo_empty[12] = 1'b0;
    wait_pulses(5, 600, "rr");
    fifo_empty = '1;
    exp_rr = '{3, 7, 12, 3, 7};
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_idx%0d", i), 64'(pulse_idx_q[i]), 64'(exp_rr[i]));
    end
    for (int i = 1; i < 5; i++) begin
      check($sformatf("rr_period%0d", i), 64'(pulse_cyc_q[i] - pulse_cyc_q[i-1]), 64'd70);
    end
    repeat (80) @(negedge fifo_clk);
    check("rr_idle_busy", 64'(busy), 64'd0);

    // Wrap: ptr is 8 after block 7, so 12 is found first, then 1.
    pulse_idx_q.delete();
    pulse_cyc_q.delete();
    fifo_empty[12] = 1'b0;
    fifo_empty[1]  = 1'b0;
    wait_pulses(2, 200, "wrap");
    fifo_empty = '1;
    check("wrap_idx0", 64'(pulse_idx_q[0]), 64'd12);
    check("wrap_idx1", 64'(pulse_idx_q[1]), 64'd1);
    repeat (80) @(negedge fifo_clk);
    check("wrap_words", 64'(words_read), 64'd7);

    // Reset during SHIFT: ptr=2 picks 6; after reset ptr=1 picks 1.
    pulse_idx_q.delete();
    pulse_cyc_q.delete();
    fifo_empty[1] = 1'b0;
    fifo_empty[6] = 1'b0;
    wait_pulses(1, 50, "mid");
    check("mid_idx", 64'(pulse_idx_q[0]), 64'd6);
    p = pulse_cyc_q[0];
    while (cyc < p + 32) @(negedge fifo_clk);
    check("mid_busy", 64'(busy), 64'd1);
    fifo_rst = 1'b1;
    repeat (2) @(negedge fifo_clk);
    check("mid_rst_valid", 64'(out_valid),  64'd0);
    check("mid_rst_words", 64'(words_read), 64'd0);
    fifo_rst = 1'b0;
    pulse_idx_q.delete();
    pulse_cyc_q.delete();
    wait_pulses(1, 20, "mid_after");
    check("mid_after_idx", 64'(pulse_idx_q[0]), 64'd1);
    fifo_empty = '1;
    wait_valid(100, "mid_after");
    check("mid_after_src",   64'(out_src),    64'd1);
    check("mid_after_data",  out_data,        blk_word(1));
    check("mid_after_words", 64'(words_read), 64'd1);
    repeat (10) @(negedge fifo_clk);

    // All empty for 1000 cycles
    n_req  = 0;
    n_busy = 0;
    repeat (1000) begin
      @(negedge fifo_clk);
      if (fifo_req != '0) n_req++;
      if (busy) n_busy++;
    end
    check("idle_req",   64'(n_req),      64'd0);
    check("idle_busy",  64'(n_busy),     64'd0);
    check("idle_words", 64'(words_read), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
